// File: rtl/rv2t_instruction_fetch.sv
// rtl/rv2t_instruction_fetch.sv - single-outstanding instruction fetch stage with redirect and timeout
module rv2t_instruction_fetch #(
    parameter int XLEN           = 32,
    parameter int PC_BITWIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   sync_reset,
    input  logic                   fetch_init,
    input  logic [PC_BITWIDTH-1:0] start_addr,
    input  logic                   fetch_next,
    input  logic                   jump_active,
    input  logic [PC_BITWIDTH-1:0] jump_addr,
    output logic                   mem_read_req,
    output logic [PC_BITWIDTH-1:0] mem_read_addr,
    input  logic                   mem_read_ack,
    input  logic [XLEN-1:0]        mem_read_data,
    output logic                   enable_out,
    output logic [XLEN-1:0]        IR_out,
    output logic [PC_BITWIDTH-1:0] PC_out,
    output logic                   exception_instr_addr_misaligned,
    output logic                   exception_fetch_timeout,
    output logic                   busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Counter value seen in the last S_REQ cycle that may still wait for an ack.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [PC_BITWIDTH-1:0] PC_STEP = PC_BITWIDTH'(4);

    logic [1:0]             state;
    logic [PC_BITWIDTH-1:0] pc;
    logic [15:0]            wait_cnt;

    logic start_misaligned;
    logic jump_misaligned;
    logic timeout_hit;

    assign start_misaligned = (start_addr[1:0] != 2'b00);
    assign jump_misaligned  = (jump_addr[1:0] != 2'b00);
    assign timeout_hit      = (wait_cnt == TIMEOUT_LAST);

    // The memory address is the fetch PC itself; busy covers any fetch in flight or held.
    assign mem_read_addr = pc;
    assign busy          = (state == S_REQ) || (state == S_HOLD);

    // Fetch sequencer: fetch_init wins in every state, then per-state request/hold handling.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state                           <= S_IDLE;
            pc                              <= '0;
            wait_cnt                        <= '0;
            mem_read_req                    <= 1'b0;
            enable_out                      <= 1'b0;
            IR_out                          <= '0;
            PC_out                          <= '0;
            exception_instr_addr_misaligned <= 1'b0;
            exception_fetch_timeout         <= 1'b0;
        end else begin
            // Strobes default low so each is exactly one cycle wide.
            enable_out                      <= 1'b0;
            exception_instr_addr_misaligned <= 1'b0;
            exception_fetch_timeout         <= 1'b0;

            if (fetch_init) begin
                // Restart abandons any pending request; a same-cycle ack is dropped.
                if (start_misaligned) begin
                    exception_instr_addr_misaligned <= 1'b1;
                    state                           <= S_IDLE;
                    mem_read_req                    <= 1'b0;
                end else begin
                    pc           <= start_addr;
                    wait_cnt     <= '0;
                    state        <= S_REQ;
                    mem_read_req <= 1'b1;
                end
            end else begin
                case (state)
                    S_REQ: begin
                        if (mem_read_ack) begin
                            // An ack on the limit cycle still delivers the word.
                            IR_out       <= mem_read_data;
                            PC_out       <= pc;
                            enable_out   <= 1'b1;
                            state        <= S_HOLD;
                            mem_read_req <= 1'b0;
                        end else if (timeout_hit) begin
                            exception_fetch_timeout <= 1'b1;
                            state                   <= S_IDLE;
                            mem_read_req            <= 1'b0;
                            wait_cnt                <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end

                    S_HOLD: begin
                        if (fetch_next) begin
                            if (jump_active) begin
                                if (jump_misaligned) begin
                                    // Bad redirect target: PC stays, fetching stops.
                                    exception_instr_addr_misaligned <= 1'b1;
                                    state                           <= S_IDLE;
                                    mem_read_req                    <= 1'b0;
                                end else begin
                                    pc           <= jump_addr;
                                    wait_cnt     <= '0;
                                    state        <= S_REQ;
                                    mem_read_req <= 1'b1;
                                end
                            end else begin
                                // Sequential advance wraps naturally at the top of the address space.
                                pc           <= pc + PC_STEP;
                                wait_cnt     <= '0;
                                state        <= S_REQ;
                                mem_read_req <= 1'b1;
                            end
                        end
                    end

                    S_IDLE: begin
                        mem_read_req <= 1'b0;
                    end

                    default: begin
                        state        <= S_IDLE;
                        mem_read_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rv2t_instruction_fetch.md
Name: rv2t_instruction_fetch

Overview:
- Front-end fetch stage that produces the instruction stream consumed by the decode stage.
- Holds the architectural fetch PC and issues single-outstanding word reads to instruction memory.
- Presents each fetched word with its PC and a one-cycle valid strobe, then waits for the controller before fetching the next word.
- Supports sequential advance, redirect (jump/branch/trap) and a bounded memory-wait timeout.

Parameters:
- XLEN, 32, instruction/data word width.
- PC_BITWIDTH, 32, width of program counter and memory address.
- TIMEOUT_CYCLES, 255, max cycles to wait for mem_read_ack (1..65535).

Ports:
- clk  input  1  clock.
- sync_reset  input  1  synchronous active-high reset.
- fetch_init  input  1  one-cycle pulse: start fetching at start_addr.
- start_addr  input  PC_BITWIDTH  initial PC, sampled with fetch_init.
- fetch_next  input  1  controller done with current instruction; advance.
- jump_active  input  1  qualifies fetch_next: redirect to jump_addr instead of PC+4.
- jump_addr  input  PC_BITWIDTH  redirect target.
- mem_read_req  output  1  read request, level, held until ack.
- mem_read_addr  output  PC_BITWIDTH  word address, equals fetch PC while requesting.
- mem_read_ack  input  1  read data valid this cycle (only honoured while mem_read_req=1).
- mem_read_data  input  XLEN  instruction word.
- enable_out  output  1  one-cycle strobe: IR_out/PC_out hold a new instruction.
- IR_out  output  XLEN  fetched instruction, stable until next enable_out.
- PC_out  output  PC_BITWIDTH  address of IR_out.
- exception_instr_addr_misaligned  output  1  one-cycle pulse, target[1:0]!=0.
- exception_fetch_timeout  output  1  one-cycle pulse, ack not received in time.
- busy  output  1  high in S_REQ and S_HOLD.

Behaviour:
- Reset (sync_reset=1 at clk edge): state S_IDLE, PC=0, timeout counter=0; mem_read_req=0, mem_read_addr=0, enable_out=0, IR_out=0, PC_out=0, both exceptions=0, busy=0. Reset overrides all inputs, including mid-request; a late ack after reset is ignored.
- All outputs registered except mem_read_addr (=PC) and busy (decoded from state).
- States: S_IDLE, S_REQ, S_HOLD.
- fetch_init has priority in every state.
  - If start_addr[1:0]!=0: pulse exception_instr_addr_misaligned, go S_IDLE.
  - Otherwise: PC<=start_addr, counter<=0, go S_REQ. Any pending request is abandoned; an ack in that same cycle is discarded.
- S_IDLE: mem_read_req=0; only fetch_init leaves it.
- S_REQ: mem_read_req=1, mem_read_addr=PC.
  - On mem_read_ack: IR_out<=mem_read_data, PC_out<=PC, enable_out=1 next cycle only, go S_HOLD.
  - Else counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack: pulse exception_fetch_timeout, go S_IDLE.
  - An ack arriving on the same cycle the counter hits its limit wins (no timeout).
- Minimum latency: ack in cycle N → enable_out in cycle N+1. With zero-wait memory (ack in the first S_REQ cycle), fetch_next→enable_out = 2 cycles.
- S_HOLD: mem_read_req=0; IR_out/PC_out held.
  - fetch_next without jump_active: PC<=PC+4 (modulo 2^PC_BITWIDTH; 0xFFFF_FFFC wraps to 0), go S_REQ.
  - fetch_next with jump_active: if jump_addr[1:0]==0, PC<=jump_addr, go S_REQ; else pulse exception_instr_addr_misaligned, PC unchanged, go S_IDLE.
- fetch_next or jump_active outside S_HOLD: ignored. mem_read_ack outside S_REQ: ignored.
- Exceptions are mutually exclusive per cycle and never coincide with enable_out.

Test Plan:
- Sequential fetch: fetch_init, start_addr=0x80, zero-wait memory returning addr^0xA5A5_0000. Pulse fetch_next after each enable_out. Expect PC_out 0x80, 0x84, 0x88, IR_out matching, enable_out one cycle wide, 2-cycle turnaround.
- Redirect: in S_HOLD at PC 0x84, fetch_next+jump_active with jump_addr=0x200 → mem_read_addr=0x200, next PC_out=0x200. Repeat with jump_addr=0x202 → misaligned pulse, state S_IDLE, mem_read_req=0.
- Wait states / timeout: ack delayed 5 cycles → enable_out 1 cycle after ack, req held high throughout. With TIMEOUT_CYCLES=8 and no ack → exception_fetch_timeout in the 8th S_REQ cycle, then req=0. Ack on the 8th cycle → instruction delivered, no timeout.
- Wrap-around: start_addr=0xFFFF_FFFC, fetch_next → mem_read_addr=0x0000_0000.
- Priority/restart: fetch_init with start_addr=0x40 in the same cycle as mem_read_ack for 0x100 → ack discarded, no enable_out, next request at 0x40.
- Reset mid-operation: sync_reset while in S_REQ → next cycle all outputs zero, state S_IDLE. Subsequent ack produces no enable_out.
